conv2_relu_pool: RTL and testbench



---
 rtl/conv2_relu_pool_if.sv | 25 ++
 rtl/conv2_relu_pool.sv | 110 +++++++++++
 tb/tb_conv2_relu_pool.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2_relu_pool_if.sv
// Stream bundle between conv2 channel-sum producer and the bias/ReLU/pool stage.
// slave = pool stage (consumes conv samples, drives pooled results); master = its environment.
interface conv2_relu_pool_if;
   logic               valid_in;
   logic signed [13:0] conv_in;
   logic signed [11:0] pool_out;
   logic               valid_out_pool;
   logic               frame_done;

   modport slave (
      input  valid_in,
      input  conv_in,
      output pool_out,
      output valid_out_pool,
      output frame_done
   );

   modport master (
      output valid_in,
      output conv_in,
      input  pool_out,
      input  valid_out_pool,
      input  frame_done
   );
endinterface

// File: rtl/conv2_relu_pool.sv
// Bias + ReLU/saturate + 2x2 stride-2 max pool per conv2 channel; result 1 cycle after a window's last sample,
// no backpressure, any valid_in pattern. Define CONV2_POOL_RELU_EN to clamp negative sums to zero.
module conv2_relu_pool #(
   parameter int                 IN_W = 8,
   parameter int                 IN_H = 8,
   parameter logic signed [13:0] BIAS = 14'sd0
) (
   input logic              clk,
   input logic              rst_n,
   conv2_relu_pool_if.slave bus
);
   localparam int CW  = $clog2(IN_W);
   localparam int RW  = $clog2(IN_H);
   localparam int LBN = IN_W / 2;
   localparam int LW  = (LBN > 1) ? $clog2(LBN) : 1;

   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic signed [11:0] tmp_q, tmp_d;
   logic signed [11:0] pool_q, pool_d;
   logic               vld_q, vld_d;
   logic               done_q, done_d;
   logic signed [11:0] lb_q [LBN];

   logic signed [14:0] sum;
   logic signed [11:0] p;
   logic [LW-1:0]      lb_idx;
   logic signed [11:0] lb_rd;
   logic               lb_we;
   logic signed [11:0] lb_wdat;
   logic               col_last, row_last;

   function automatic logic signed [11:0] smax(input logic signed [11:0] a,
                                               input logic signed [11:0] b);
      return (a > b) ? a : b;
   endfunction

   assign sum = {bus.conv_in[13], bus.conv_in} + {BIAS[13], BIAS};

   always_comb begin
      if (sum > 15'sd2047)       p = 12'sh7FF;
      else if (sum < -15'sd2048) p = 12'sh800;
      else                       p = sum[11:0];
`ifdef CONV2_POOL_RELU_EN
      if (sum[14]) p = '0;
`endif
   end

   assign lb_idx   = LW'(col_q >> 1);
   assign lb_rd    = lb_q[lb_idx];
   assign col_last = (col_q == CW'(IN_W - 1));
   assign row_last = (row_q == RW'(IN_H - 1));

   // Even row pairs horizontally into the line buffer; odd row folds it in and emits on odd column.
   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      tmp_d   = tmp_q;
      pool_d  = pool_q;
      vld_d   = 1'b0;
      done_d  = 1'b0;
      lb_we   = 1'b0;
      lb_wdat = smax(tmp_q, p);
      if (bus.valid_in) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         case ({row_q[0], col_q[0]})
            2'b00: tmp_d = p;
            2'b01: lb_we = 1'b1;
            2'b10: tmp_d = smax(lb_rd, p);
            default: begin
               pool_d = smax(tmp_q, p);
               vld_d  = 1'b1;
               done_d = row_last && col_last;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q  <= '0;
         row_q  <= '0;
         tmp_q  <= '0;
         pool_q <= '0;
         vld_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         tmp_q  <= tmp_d;
         pool_q <= pool_d;
         vld_q  <= vld_d;
         done_q <= done_d;
      end
   end

   // Every entry is written on an even row before the odd row reads it, so no reset is needed.
   always_ff @(posedge clk) begin
      if (lb_we) lb_q[lb_idx] <= lb_wdat;
   end

   assign bus.pool_out       = pool_q;
   assign bus.valid_out_pool = vld_q;
   assign bus.frame_done     = done_q;
endmodule

// File: tb/tb_conv2_relu_pool.sv
// Directed bench for conv2_relu_pool: two instances (BIAS 0 and BIAS -10) share one input stream.
// Expected values follow the ReLU build selected by CONV2_POOL_RELU_EN.
`timescale 1ns/1ps
module tb_conv2_relu_pool;
   localparam int W = 8;
   localparam int H = 8;
`ifdef CONV2_POOL_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv2_relu_pool_if if_a ();
   conv2_relu_pool_if if_b ();

   conv2_relu_pool #(.IN_W(W), .IN_H(H), .BIAS(14'sd0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   conv2_relu_pool #(.IN_W(W), .IN_H(H), .BIAS(-14'sd10)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

   assign if_b.valid_in = if_a.valid_in;
   assign if_b.conv_in  = if_a.conv_in;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_edge = 0;
   int stray_done = 0;

   logic signed [13:0] frame [W*H];
   logic signed [11:0] mon_val[$];
   int                 mon_cyc[$];
   logic               mon_done[$];
   logic signed [11:0] monb_val[$];
   logic signed [11:0] exp_q[$];
   int                 exp_edge[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (if_a.valid_out_pool === 1'b1) begin
         mon_val.push_back(if_a.pool_out);
         mon_cyc.push_back(cyc);
         mon_done.push_back(if_a.frame_done);
      end else if (if_a.frame_done === 1'b1) begin
         stray_done++;
      end
      if (if_b.valid_out_pool === 1'b1) monb_val.push_back(if_b.pool_out);
   end

   // Independent reference: biased value, optional clamp at zero, 12-bit saturation.
   function automatic logic signed [11:0] pp(input logic signed [13:0] x, input int b);
      int s;
      s = int'(x) + b;
      if (RELU && s < 0) s = 0;
      if (s > 2047) s = 2047;
      if (s < -2048) s = -2048;
      return 12'(s);
   endfunction

   function automatic logic signed [11:0] win_exp(input int pr, input int pc, input int b);
      logic signed [11:0] m, v;
      m = pp(frame[(2*pr)*W + 2*pc], b);
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++) begin
            v = pp(frame[(2*pr+dr)*W + 2*pc + dc], b);
            if (v > m) m = v;
         end
      return m;
   endfunction

   task automatic send(input logic signed [13:0] v, input int gap);
      @(negedge clk);
      if_a.valid_in = 1'b1;
      if_a.conv_in  = v;
      last_edge     = cyc + 1;
      repeat (gap) begin
         @(negedge clk);
         if_a.valid_in = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         if_a.valid_in = 1'b0;
      end
   endtask

   task automatic send_frame(input int gmode);
      int g;
      for (int i = 0; i < W*H; i++) begin
         g = (gmode < 0) ? int'($urandom_range(0, 5)) : gmode;
         send(frame[i], g);
         if (((i / W) % 2 == 1) && ((i % W) % 2 == 1)) exp_edge.push_back(last_edge);
      end
   endtask

   task automatic clear_mon();
      mon_val.delete(); mon_cyc.delete(); mon_done.delete(); monb_val.delete();
      exp_q.delete(); exp_edge.delete();
      stray_done = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if_a.valid_in = 1'b0;
      if_a.conv_in  = '0;
      repeat (3) @(negedge clk);
      tests++;
      if (if_a.pool_out !== 12'sd0) begin
         fails++; $display("FAIL reset_pool_out: got %0d expected 0", if_a.pool_out);
      end
      tests++;
      if (if_a.valid_out_pool !== 1'b0) begin
         fails++; $display("FAIL reset_valid: got %b expected 0", if_a.valid_out_pool);
      end
      tests++;
      if (if_a.frame_done !== 1'b0) begin
         fails++; $display("FAIL reset_frame_done: got %b expected 0", if_a.frame_done);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      clear_mon();
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if_a.valid_in = 1'b0;
         tests++;
         if (if_a.pool_out !== 12'sd0 || if_a.valid_out_pool !== 1'b0 || if_a.frame_done !== 1'b0) begin
            fails++;
            $display("FAIL idle[%0d]: got pool=%0d vld=%b done=%b expected 0/0/0",
                     c, if_a.pool_out, if_a.valid_out_pool, if_a.frame_done);
         end
      end
   endtask

   task automatic test_ramp();
      int e;
      clear_mon();
      for (int i = 0; i < W*H; i++) frame[i] = 14'(i);
      send_frame(1);
      idle(3);
      tests++;
      if (mon_val.size() != 16) begin
         fails++; $display("FAIL ramp_count: got %0d expected 16", mon_val.size());
      end
      for (int k = 0; k < mon_val.size() && k < 16; k++) begin
         e = (2*(k/4) + 1) * 8 + 2*(k%4) + 1;
         tests++;
         if (mon_val[k] !== 12'(e)) begin
            fails++; $display("FAIL ramp_val[%0d]: got %0d expected %0d", k, mon_val[k], e);
         end
         tests++;
         if (mon_cyc[k] != exp_edge[k]) begin
            fails++; $display("FAIL ramp_latency[%0d]: got edge %0d expected %0d", k, mon_cyc[k], exp_edge[k]);
         end
         tests++;
         if (mon_done[k] !== (k == 15)) begin
            fails++; $display("FAIL ramp_done[%0d]: got %b expected %b", k, mon_done[k], (k == 15));
         end
      end
      tests++;
      if (stray_done != 0) begin
         fails++; $display("FAIL ramp_stray_done: got %0d expected 0", stray_done);
      end
   endtask

   task automatic test_negative();
      logic signed [11:0] ea, eb;
      ea = RELU ? 12'sd0 : 12'shF9C;
      eb = RELU ? 12'sd0 : -12'sd110;
      clear_mon();
      for (int i = 0; i < W*H; i++) frame[i] = -14'sd100;
      send_frame(1);
      idle(3);
      tests++;
      if (mon_val.size() != 16 || monb_val.size() != 16) begin
         fails++; $display("FAIL neg_count: got %0d/%0d expected 16/16", mon_val.size(), monb_val.size());
      end
      for (int k = 0; k < mon_val.size() && k < 16; k++) begin
         tests++;
         if (mon_val[k] !== ea) begin
            fails++; $display("FAIL neg_val_a[%0d]: got %0d expected %0d", k, mon_val[k], ea);
         end
      end
      for (int k = 0; k < monb_val.size() && k < 16; k++) begin
         tests++;
         if (monb_val[k] !== eb) begin
            fails++; $display("FAIL neg_val_b[%0d]: got %0d expected %0d", k, monb_val[k], eb);
         end
      end
   endtask

   task automatic test_saturation();
      logic signed [11:0] ea [16];
      logic signed [11:0] eb [16];
      clear_mon();
      for (int i = 0; i < W*H; i++) frame[i] = 14'sd0;
      frame[0]  = 14'sd8191;
      frame[2]  = 14'sd5;  frame[3]  = 14'sd3;
      frame[10] = 14'sd2;  frame[11] = 14'sd1;
      frame[16] = -14'sd8192; frame[17] = -14'sd8192;
      frame[24] = -14'sd8192; frame[25] = -14'sd8192;
      for (int k = 0; k < 16; k++) begin
         ea[k] = 12'sd0;
         eb[k] = RELU ? 12'sd0 : -12'sd10;
      end
      ea[0] = 12'sd2047;                       eb[0] = 12'sd2047;
      ea[1] = 12'sd5;                          eb[1] = RELU ? 12'sd0 : -12'sd5;
      ea[4] = RELU ? 12'sd0 : 12'sh800;        eb[4] = RELU ? 12'sd0 : 12'sh800;
      send_frame(0);
      idle(3);
      tests++;
      if (mon_val.size() != 16 || monb_val.size() != 16) begin
         fails++; $display("FAIL sat_count: got %0d/%0d expected 16/16", mon_val.size(), monb_val.size());
      end
      for (int k = 0; k < mon_val.size() && k < 16; k++) begin
         tests++;
         if (mon_val[k] !== ea[k]) begin
            fails++; $display("FAIL sat_val_a[%0d]: got %0d expected %0d", k, mon_val[k], ea[k]);
         end
      end
      for (int k = 0; k < monb_val.size() && k < 16; k++) begin
         tests++;
         if (monb_val[k] !== eb[k]) begin
            fails++; $display("FAIL sat_val_b[%0d]: got %0d expected %0d", k, monb_val[k], eb[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < W*H; i++) frame[i] = 14'($urandom_range(0, 16383));
         for (int pr = 0; pr < H/2; pr++)
            for (int pc = 0; pc < W/2; pc++) exp_q.push_back(win_exp(pr, pc, 0));
         send_frame((f < 2) ? 0 : -1);
      end
      idle(3);
      tests++;
      if (mon_val.size() != 48) begin
         fails++; $display("FAIL b2b_count: got %0d expected 48", mon_val.size());
      end
      for (int k = 0; k < mon_val.size() && k < 48; k++) begin
         tests++;
         if (mon_val[k] !== exp_q[k]) begin
            fails++; $display("FAIL b2b_val[%0d]: got %0d expected %0d", k, mon_val[k], exp_q[k]);
         end
         tests++;
         if (mon_cyc[k] != exp_edge[k]) begin
            fails++; $display("FAIL b2b_latency[%0d]: got edge %0d expected %0d", k, mon_cyc[k], exp_edge[k]);
         end
         tests++;
         if (mon_done[k] !== (k % 16 == 15)) begin
            fails++; $display("FAIL b2b_done[%0d]: got %b expected %b", k, mon_done[k], (k % 16 == 15));
         end
      end
      tests++;
      if (stray_done != 0) begin
         fails++; $display("FAIL b2b_stray_done: got %0d expected 0", stray_done);
      end
   endtask

   task automatic test_mid_reset();
      int e, ndone;
      clear_mon();
      for (int i = 0; i < 37; i++) send(14'sd1000 + 14'(i), 1);
      @(negedge clk);
      if_a.valid_in = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tests++;
      if (if_a.pool_out !== 12'sd0 || if_a.valid_out_pool !== 1'b0 || if_a.frame_done !== 1'b0) begin
         fails++;
         $display("FAIL midrst_outputs: got pool=%0d vld=%b done=%b expected 0/0/0",
                  if_a.pool_out, if_a.valid_out_pool, if_a.frame_done);
      end
      clear_mon();
      for (int i = 0; i < W*H; i++) frame[i] = 14'(63 - i);
      send_frame(1);
      idle(3);
      tests++;
      if (mon_val.size() != 16) begin
         fails++; $display("FAIL midrst_count: got %0d expected 16", mon_val.size());
      end
      ndone = 0;
      for (int k = 0; k < mon_val.size() && k < 16; k++) begin
         e = 63 - (16*(k/4) + 2*(k%4));
         if (mon_done[k]) ndone++;
         tests++;
         if (mon_val[k] !== 12'(e)) begin
            fails++; $display("FAIL midrst_val[%0d]: got %0d expected %0d", k, mon_val[k], e);
         end
         tests++;
         if (mon_cyc[k] != exp_edge[k]) begin
            fails++; $display("FAIL midrst_latency[%0d]: got edge %0d expected %0d", k, mon_cyc[k], exp_edge[k]);
         end
      end
      tests++;
      if (ndone != 1 || (mon_done.size() == 16 && mon_done[15] !== 1'b1)) begin
         fails++; $display("FAIL midrst_done: got %0d pulses expected 1 on the 16th output", ndone);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_ramp();
      test_negative();
      test_saturation();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
